// File: rtl/rv32i_types.sv
// Shared RV32I types: instruction layout, opcodes and the multicycle controller's
// state, select and halt-cause encodings.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        HALT    = 3'd4
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4    = 2'd0,
        PC_ALU      = 2'd1,
        PC_ALU_MOD2 = 2'd2
    } pc_sel_t;

    typedef enum logic [2:0] {
        RD_ALU  = 3'd0,
        RD_CMP  = 3'd1,
        RD_UIMM = 3'd2,
        RD_PC4  = 3'd3,
        RD_LOAD = 3'd4
    } rd_sel_t;

    typedef enum logic [1:0] {
        HC_NONE     = 2'd0,
        HC_ILLEGAL  = 2'd1,
        HC_MISALIGN = 2'd2,
        HC_TIMEOUT  = 2'd3
    } halt_cause_t;

    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_ALU = 1'b1;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    // Access size lives in funct3[1:0]; funct3[2] only selects sign/zero extension.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic instr_legal(instr_t i);
        logic ok;
        ok = 1'b0;
        case (i.opcode)
            op_lui, op_auipc, op_jal, op_jalr, op_br, op_imm, op_reg: ok = 1'b1;
            op_load:  ok = (i.funct3[1:0] != 2'b11) && !(i.funct3[2] && i.funct3[1]);
            op_store: ok = !i.funct3[2] && (i.funct3[1:0] != 2'b11);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32i_mask_gen.sv
// Byte-lane mask and alignment check for a load or store, from funct3 and the
// low address bits.
module rv32i_mask_gen
    import rv32i_types::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] mem_addr_lsb,
    input  logic       is_store,
    output logic [3:0] rmask,
    output logic [3:0] wmask,
    output logic       misaligned
);

    logic [3:0] mask;
    logic       unused_sign;

    // Extension kind does not affect which lanes are touched.
    assign unused_sign = funct3[2];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        mask       = 4'b0000;
        misaligned = 1'b0;
        case (funct3[1:0])
            SZ_B: mask = 4'b0001 << mem_addr_lsb;
            SZ_H: begin
                mask       = 4'b0011 << mem_addr_lsb;
                misaligned = mem_addr_lsb[0];
            end
            SZ_W: begin
                mask       = 4'b1111;
                misaligned = |mem_addr_lsb;
            end
            default: ;
        endcase
    end

    assign rmask = is_store ? 4'b0000 : mask;
    assign wmask = is_store ? mask : 4'b0000;

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multicycle RV32I control FSM around one shared memory port.
// Define MC_CTRL_ORDER_EN to build the 64-bit retired-instruction counter on order.
module rv32i_mc_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_resp,
    input  logic [31:0] ir,
    input  logic        br_en,
    input  logic [1:0]  mem_addr_lsb,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic        addr_sel,
    output logic        load_ir,
    output logic        load_pc,
    output logic [1:0]  pc_sel,
    output logic        load_rd,
    output logic [2:0]  rd_sel,
    output logic        commit,
    output logic [63:0] order,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    instr_t            instr;
    ctrl_state_t       state, state_n;
    halt_cause_t       cause_q, cause_n;
    logic              rst_hold;
    logic [CNT_W-1:0]  wait_cnt;
    logic              is_load, is_store, rd_nz;
    logic              req_active, timeout;
    logic [3:0]        ls_rmask, ls_wmask;
    logic              misaligned;
    logic              unused_fields;

    assign instr         = instr_t'(ir);
    assign is_load       = (instr.opcode == op_load);
    assign is_store      = (instr.opcode == op_store);
    assign rd_nz         = (instr.rd != 5'd0);
    assign unused_fields = ^{instr.funct7, instr.rs1, instr.rs2};

    rv32i_mask_gen u_mask_gen (
        .funct3       (instr.funct3),
        .mem_addr_lsb (mem_addr_lsb),
        .is_store     (is_store),
        .rmask        (ls_rmask),
        .wmask        (ls_wmask),
        .misaligned   (misaligned)
    );

    // rst_hold keeps the outputs quiet for the cycle following a reset edge.
    assign req_active = !rst_hold && ((state == FETCH) || (state == MEM));
    assign timeout    = req_active && !mem_resp && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_n    = state;
        cause_n    = cause_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_rmask  = 4'b0000;
        mem_wmask  = 4'b0000;
        addr_sel   = ADDR_SEL_PC;
        load_ir    = 1'b0;
        load_pc    = 1'b0;
        pc_sel     = PC_PLUS4;
        load_rd    = 1'b0;
        rd_sel     = RD_ALU;
        commit     = 1'b0;
        halted     = 1'b0;
        halt_cause = HC_NONE;
        if (!rst_hold) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    mem_rmask = 4'b1111;
                    addr_sel  = ADDR_SEL_PC;
                    if (mem_resp) begin
                        load_ir = 1'b1;
                        state_n = DECODE;
                    end else if (timeout) begin
                        state_n = HALT;
                        cause_n = HC_TIMEOUT;
                    end
                end
                DECODE: begin
                    if (!instr_legal(instr)) begin
                        state_n = HALT;
                        cause_n = HC_ILLEGAL;
                    end else begin
                        state_n = EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (is_load || is_store) begin
                        if (misaligned) begin
                            state_n = HALT;
                            cause_n = HC_MISALIGN;
                        end else begin
                            state_n = MEM;
                        end
                    end else begin
                        load_pc = 1'b1;
                        commit  = 1'b1;
                        load_rd = (instr.opcode != op_br) && rd_nz;
                        state_n = FETCH;
                        case (instr.opcode)
                            op_lui:   rd_sel = RD_UIMM;
                            op_auipc: rd_sel = RD_ALU;
                            op_imm, op_reg:
                                rd_sel = ((instr.funct3 == F3_SLT) || (instr.funct3 == F3_SLTU))
                                         ? RD_CMP : RD_ALU;
                            op_jal: begin
                                rd_sel = RD_PC4;
                                pc_sel = PC_ALU;
                            end
                            op_jalr: begin
                                rd_sel = RD_PC4;
                                pc_sel = PC_ALU_MOD2;
                            end
                            op_br:   pc_sel = br_en ? PC_ALU : PC_PLUS4;
                            default: ;
                        endcase
                    end
                end
                MEM: begin
                    addr_sel  = ADDR_SEL_ALU;
                    mem_read  = is_load;
                    mem_write = is_store;
                    mem_rmask = ls_rmask;
                    mem_wmask = ls_wmask;
                    if (mem_resp) begin
                        load_pc = 1'b1;
                        pc_sel  = PC_PLUS4;
                        commit  = 1'b1;
                        load_rd = is_load && rd_nz;
                        if (is_load) rd_sel = RD_LOAD;
                        state_n = FETCH;
                    end else if (timeout) begin
                        state_n = HALT;
                        cause_n = HC_TIMEOUT;
                    end
                end
                HALT: begin
                    halted     = 1'b1;
                    halt_cause = cause_q;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            cause_q  <= HC_NONE;
            rst_hold <= 1'b1;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            cause_q  <= cause_n;
            rst_hold <= 1'b0;
            wait_cnt <= (req_active && !mem_resp) ? wait_cnt + CNT_W'(1) : '0;
        end
    end

`ifdef MC_CTRL_ORDER_EN
    logic [63:0] order_q;

    always_ff @(posedge clk) begin
        if (rst)         order_q <= 64'd0;
        else if (commit) order_q <= order_q + 64'd1;
    end

    assign order = order_q;
`else
    assign order = 64'd0;
`endif

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed bench for rv32i_mc_ctrl: instruction sequences with hand-computed
// strobe values, misalignment, illegal opcode, timeout and reset cases.
module tb_rv32i_mc_ctrl;

    localparam int unsigned TO = 4;
`ifdef MC_CTRL_ORDER_EN
    localparam bit ORDER_EN = 1'b1;
`else
    localparam bit ORDER_EN = 1'b0;
`endif

    logic        clk, rst, mem_resp, br_en;
    logic [31:0] ir;
    logic [1:0]  mem_addr_lsb;
    logic        mem_read, mem_write, addr_sel, load_ir, load_pc, load_rd, commit, halted;
    logic [3:0]  mem_rmask, mem_wmask;
    logic [1:0]  pc_sel, halt_cause;
    logic [2:0]  rd_sel;
    logic [63:0] order;
    logic [22:0] outs;

    int          n_checks, n_fail;
    logic [63:0] exp_order;

    rv32i_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_resp     (mem_resp),
        .ir           (ir),
        .br_en        (br_en),
        .mem_addr_lsb (mem_addr_lsb),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rmask    (mem_rmask),
        .mem_wmask    (mem_wmask),
        .addr_sel     (addr_sel),
        .load_ir      (load_ir),
        .load_pc      (load_pc),
        .pc_sel       (pc_sel),
        .load_rd      (load_rd),
        .rd_sel       (rd_sel),
        .commit       (commit),
        .order        (order),
        .halted       (halted),
        .halt_cause   (halt_cause)
    );

    assign outs = {mem_read, mem_write, mem_rmask, mem_wmask, addr_sel, load_ir, load_pc,
                   pc_sel, load_rd, rd_sel, commit, halted, halt_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_resp = 1'b0;
        cyc();
        cyc();
        mid();
        check("reset.outs", outs, 0);
        check("reset.order", order, 0);
        cyc();
        rst = 1'b0;
        cyc();
        exp_order = 0;
    endtask

    // Starts at the beginning of a FETCH cycle, ends at the beginning of EXECUTE.
    task automatic fetch(input logic [31:0] instr, input int wait_cycles, input string tag);
        for (int i = 0; i < wait_cycles; i++) begin
            mem_resp = 1'b0;
            mid();
            check({tag, ".fetch_wait"}, {mem_read, mem_rmask, addr_sel, load_ir, halted},
                  {1'b1, 4'hF, 1'b0, 1'b0, 1'b0});
            cyc();
        end
        ir = instr;
        mem_resp = 1'b1;
        mid();
        check({tag, ".fetch"}, {mem_read, mem_rmask, addr_sel, load_ir},
              {1'b1, 4'hF, 1'b0, 1'b1});
        cyc();
        mem_resp = 1'b0;
        mid();
        check({tag, ".decode"}, {commit, load_pc, load_rd, mem_read, halted}, 0);
        cyc();
    endtask

    task automatic exec_nonmem(input string tag, input logic e_load_rd, input int e_rd_sel,
                               input logic [1:0] e_pc_sel);
        mid();
        check({tag, ".exec"}, {load_pc, commit, load_rd, pc_sel, mem_read, mem_write, halted},
              {1'b1, 1'b1, e_load_rd, e_pc_sel, 3'b000});
        if (e_rd_sel >= 0) check({tag, ".rd_sel"}, rd_sel, e_rd_sel[2:0]);
        exp_order++;
        cyc();
        check({tag, ".order"}, order, ORDER_EN ? exp_order : 64'd0);
    endtask

    task automatic exec_mem(input string tag);
        mid();
        check({tag, ".exec"}, {commit, load_pc, load_rd, mem_read, mem_write, halted}, 0);
        cyc();
    endtask

    task automatic mem_phase(input string tag, input int delay, input logic is_load,
                             input logic [3:0] mask, input logic e_load_rd);
        logic [10:0] e_req;
        e_req = {1'b1, is_load, !is_load, is_load ? mask : 4'h0, is_load ? 4'h0 : mask};
        for (int i = 0; i <= delay; i++) begin
            mem_resp = (i == delay);
            mid();
            check({tag, ".mreq"}, {addr_sel, mem_read, mem_write, mem_rmask, mem_wmask}, e_req);
            check({tag, ".retire"}, {commit, load_pc, load_rd},
                  (i == delay) ? {1'b1, 1'b1, e_load_rd} : 3'b000);
            if (i == delay) begin
                check({tag, ".pc_sel"}, pc_sel, 2'd0);
                if (is_load) check({tag, ".rd_sel"}, rd_sel, 3'd4);
            end
            cyc();
        end
        mem_resp = 1'b0;
        exp_order++;
        check({tag, ".order"}, order, ORDER_EN ? exp_order : 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_order = 0;
        rst = 1'b1;
        mem_resp = 1'b0;
        ir = 32'h0;
        br_en = 1'b0;
        mem_addr_lsb = 2'b00;
        do_reset();

        // ALU-class instructions, response in the first FETCH cycle
        fetch(32'h00500093, 0, "addi");
        exec_nonmem("addi", 1'b1, 0, 2'd0);
        fetch(32'h0030A113, 0, "slti");
        exec_nonmem("slti", 1'b1, 1, 2'd0);
        fetch(32'h123451B7, 0, "lui");
        exec_nonmem("lui", 1'b1, 2, 2'd0);
        fetch(32'h008000EF, 0, "jal");
        exec_nonmem("jal", 1'b1, 3, 2'd1);

        // lh at lsb=10, response on the 4th MEM cycle (also the timeout boundary)
        mem_addr_lsb = 2'b10;
        fetch(32'h00009203, 1, "lh");
        exec_mem("lh");
        mem_phase("lh", 3, 1'b1, 4'b1100, 1'b1);

        // sb at lsb=11
        mem_addr_lsb = 2'b11;
        fetch(32'h00208023, 0, "sb");
        exec_mem("sb");
        mem_phase("sb", 0, 1'b0, 4'b1000, 1'b0);

        // sw at lsb=01 is misaligned
        mem_addr_lsb = 2'b01;
        fetch(32'h0020A023, 0, "sw");
        exec_mem("sw");
        mid();
        check("sw.halt", {halted, halt_cause, commit, mem_write, mem_read}, {1'b1, 2'd2, 3'b000});
        cyc();
        mem_resp = 1'b1;
        cyc();
        mid();
        check("sw.sticky", {halted, halt_cause, mem_read, load_ir}, {1'b1, 2'd2, 2'b00});
        do_reset();

        // branches and jalr to x0
        mem_addr_lsb = 2'b00;
        br_en = 1'b1;
        fetch(32'h00000463, 0, "beq_taken");
        exec_nonmem("beq_taken", 1'b0, -1, 2'd1);
        br_en = 1'b0;
        fetch(32'h00000463, 0, "beq_not");
        exec_nonmem("beq_not", 1'b0, -1, 2'd0);
        fetch(32'h00008067, 0, "jalr_x0");
        exec_nonmem("jalr_x0", 1'b0, 3, 2'd2);

        // illegal opcode
        fetch(32'hFFFFFFFF, 0, "illegal");
        mid();
        check("illegal.halt", {halted, halt_cause, commit, load_pc, load_rd}, {1'b1, 2'd1, 3'b000});
        cyc();
        mem_resp = 1'b1;
        cyc();
        mid();
        check("illegal.sticky", {halted, halt_cause, mem_read, load_ir}, {1'b1, 2'd1, 2'b00});
        do_reset();

        // FETCH timeout after TO cycles without a response
        for (int i = 0; i < TO; i++) begin
            mem_resp = 1'b0;
            mid();
            check("timeout.wait", {mem_read, halted}, 2'b10);
            cyc();
        end
        mid();
        check("timeout.halt", {halted, halt_cause, mem_read}, {1'b1, 2'd3, 1'b0});
        do_reset();

        // response on the last allowed cycle wins over the timeout
        fetch(32'h00500093, TO - 1, "resp_at_limit");
        exec_nonmem("resp_at_limit", 1'b1, 0, 2'd0);

        // reset asserted in the middle of a MEM access
        mem_addr_lsb = 2'b00;
        fetch(32'h0000A283, 0, "lw");
        exec_mem("lw");
        mid();
        check("lw.mreq", {mem_read, addr_sel, mem_rmask}, {1'b1, 1'b1, 4'hF});
        rst = 1'b1;
        cyc();
        mid();
        check("rst_mid.outs", outs, 0);
        check("rst_mid.order", order, 0);
        rst = 1'b0;
        cyc();
        mid();
        check("rst_release.fetch", {mem_read, addr_sel, mem_rmask}, {1'b1, 1'b0, 4'hF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
